// File: rtl/ctrl_pipe.sv
// Execute/memory/writeback control pipeline for the 5-stage ARM core.
// Carries hazard-relevant control fields, derives forwarding/load-use matches and counts E bubbles.
module ctrl_pipe #(
    parameter int AW = 4,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] RA1D,
    input  logic [AW-1:0] RA2D,
    input  logic [AW-1:0] WA3D,
    input  logic          RegWriteD,
    input  logic          MemtoRegD,
    input  logic          MemWriteD,
    input  logic          FlushE,
    output logic [AW-1:0] RA1E,
    output logic [AW-1:0] RA2E,
    output logic [AW-1:0] WA3E,
    output logic          RegWriteE,
    output logic          MemtoRegE,
    output logic          MemWriteE,
    output logic [AW-1:0] WA3M,
    output logic          RegWriteM,
    output logic          MemtoRegM,
    output logic          MemWriteM,
    output logic [AW-1:0] WA3W,
    output logic          RegWriteW,
    output logic          MemtoRegW,
    output logic          Match_1E_M,
    output logic          Match_1E_W,
    output logic          Match_2E_M,
    output logic          Match_2E_W,
    output logic          Match,
    output logic [CW-1:0] BubbleCount
);

    // The all-ones address is the PC, which is never forwarded from the pipeline.
    localparam logic [AW-1:0] PC_ADDR = '1;

    function automatic logic src_hit(input logic [AW-1:0] ra, input logic [AW-1:0] wa);
        return (ra == wa) && (ra != PC_ADDR);
    endfunction

    // NOTE: sequential state uses non-blocking assignments so every bank samples the
    // pre-edge value of its upstream bank, which is what makes the pipeline shift.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            RA1E      <= '0;
            RA2E      <= '0;
            WA3E      <= '0;
            RegWriteE <= 1'b0;
            MemtoRegE <= 1'b0;
            MemWriteE <= 1'b0;
        end else if (FlushE) begin
            RA1E      <= '0;
            RA2E      <= '0;
            WA3E      <= '0;
            RegWriteE <= 1'b0;
            MemtoRegE <= 1'b0;
            MemWriteE <= 1'b0;
        end else begin
            RA1E      <= RA1D;
            RA2E      <= RA2D;
            WA3E      <= WA3D;
            RegWriteE <= RegWriteD;
            MemtoRegE <= MemtoRegD;
            MemWriteE <= MemWriteD;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            WA3M      <= '0;
            RegWriteM <= 1'b0;
            MemtoRegM <= 1'b0;
            MemWriteM <= 1'b0;
            WA3W      <= '0;
            RegWriteW <= 1'b0;
            MemtoRegW <= 1'b0;
        end else begin
            WA3M      <= WA3E;
            RegWriteM <= RegWriteE;
            MemtoRegM <= MemtoRegE;
            MemWriteM <= MemWriteE;
            WA3W      <= WA3M;
            RegWriteW <= RegWriteM;
            MemtoRegW <= MemtoRegM;
        end
    end

    // Saturating bubble counter; it never wraps and only reset clears it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            BubbleCount <= '0;
        end else if (FlushE && (BubbleCount != '1)) begin
            BubbleCount <= BubbleCount + CW'(1);
        end
    end

    assign Match_1E_M = RegWriteM & src_hit(RA1E, WA3M);
    assign Match_1E_W = RegWriteW & src_hit(RA1E, WA3W);
    assign Match_2E_M = RegWriteM & src_hit(RA2E, WA3M);
    assign Match_2E_W = RegWriteW & src_hit(RA2E, WA3W);

    // Load-use looks at the raw Decode addresses against the load currently in E.
    assign Match = MemtoRegE & RegWriteE & (src_hit(RA1D, WA3E) | src_hit(RA2D, WA3E));

endmodule
